mem_port_arbiter: RTL

Shares the single unified memory port of the MIPS32 core between instruction fetch (I) and data load/store (D). Sits between the fetch/MEM stages and the memory model instantiated under top. Uses data-first priority with a starvation limit for fetch and a per-transaction ready timeout. One transaction is outstanding at a time.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// Data-first priority with a fetch starvation limit; one transaction outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned D_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    localparam logic [3:0] StreakMax = 4'(D_STREAK_MAX);
    localparam logic [9:0] TmoLimit  = 10'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

    state_e      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [9:0]  tmo_q, tmo_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [3:0]  m_be_q, m_be_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic elig_i, elig_d, grant_i, grant_d, expire;

    // A requester being acked this cycle still shows req; it must not be re-granted.
    assign elig_i  = i_req & ~i_ack_q;
    assign elig_d  = d_req & ~d_ack_q;
    assign grant_d = elig_d & (~elig_i | (streak_q != StreakMax));
    assign grant_i = elig_i & ~grant_d;
    assign expire  = (TIMEOUT != 0) && !m_ready && (tmo_q == TmoLimit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            streak_q  <= '0;
            tmo_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            bus_err_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            bus_err_q <= bus_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StGrantD;
                end else if (grant_i) begin
                    state_d = StGrantI;
                end
            end
            StGrantI, StGrantD: begin
                if (m_ready || expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        bus_err_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    tmo_d     = '0;
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_i) begin
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_be_d    = 4'hF;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    tmo_d     = '0;
                    streak_d  = '0;
                end
            end
            StGrantI, StGrantD: begin
                // m_ready takes precedence over an expiring timeout in the same cycle.
                if (m_ready) begin
                    m_req_d = 1'b0;
                    if (state_q == StGrantI) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end else if (expire) begin
                    m_req_d   = 1'b0;
                    bus_err_d = 1'b1;
                    i_ack_d   = (state_q == StGrantI);
                    d_ack_d   = (state_q == StGrantD);
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            default: ;
        endcase
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign bus_err = bus_err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
